// File: rtl/hazard_ctrl.sv
// Hazard/bypass controller: tracks EX/MEM/WB write flags, forwards, stalls on load-use.
// Optional stall counter port o_stall_cnt enabled by HAZ_STALL_CNT_EN.
module hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [RA_W-1:0] i_rs,
  input  logic [RA_W-1:0] i_rt,
  input  logic            i_use_rs,
  input  logic            i_use_rt,
  input  logic [RA_W-1:0] i_rw_d,
  input  logic            i_regwr_d,
  input  logic            i_memread_d,
  input  logic [RA_W-1:0] i_rw_ex,
  input  logic [RA_W-1:0] i_rw_mem,
  input  logic [RA_W-1:0] i_rw_w,
  input  logic            i_flush,
  output logic [1:0]      o_asrc,
  output logic [1:0]      o_bsrc,
  output logic            o_stall,
  output logic            o_ex_regwr,
  output logic            o_mem_regwr,
  output logic            o_wb_regwr
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt
`endif
);

  logic ex_regwr;
  logic ex_load;
  logic mem_regwr;
  logic wb_regwr;
  logic bubble;
  logic wr_d;
  logic rs_ld_hit;
  logic rt_ld_hit;

  function automatic logic [1:0] sel(
    input logic            use_x,
    input logic [RA_W-1:0] x,
    input logic            exw,
    input logic [RA_W-1:0] ex_a,
    input logic            memw,
    input logic [RA_W-1:0] mem_a,
    input logic            wbw,
    input logic [RA_W-1:0] wb_a
  );
    logic [1:0] s;
    s = 2'b00;
    // youngest producer wins
    if (!use_x || x == '0)
      s = 2'b00;
    else if (exw && ex_a == x)
      s = 2'b01;
    else if (memw && mem_a == x)
      s = 2'b10;
    else if (wbw && wb_a == x)
      s = 2'b11;
    return s;
  endfunction

  always_comb begin
    rs_ld_hit = i_use_rs && (i_rs != '0)
             && (i_rs == i_rw_ex);
    rt_ld_hit = i_use_rt && (i_rt != '0)
             && (i_rt == i_rw_ex);
    o_stall = ex_load && (rs_ld_hit || rt_ld_hit);
    bubble = o_stall || i_flush;
    wr_d = i_regwr_d && (i_rw_d != '0);
  end

  always_comb begin
    o_asrc = sel(i_use_rs, i_rs,
                 ex_regwr, i_rw_ex,
                 mem_regwr, i_rw_mem,
                 wb_regwr, i_rw_w);
    o_bsrc = sel(i_use_rt, i_rt,
                 ex_regwr, i_rw_ex,
                 mem_regwr, i_rw_mem,
                 wb_regwr, i_rw_w);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ex_regwr  <= 1'b0;
      ex_load   <= 1'b0;
      mem_regwr <= 1'b0;
      wb_regwr  <= 1'b0;
    end else begin
      ex_regwr  <= bubble ? 1'b0 : wr_d;
      ex_load   <= bubble ? 1'b0
                 : (wr_d && i_memread_d);
      mem_regwr <= ex_regwr;
      wb_regwr  <= mem_regwr;
    end
  end

  assign o_ex_regwr  = ex_regwr;
  assign o_mem_regwr = mem_regwr;
  assign o_wb_regwr  = wb_regwr;

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      stall_cnt <= '0;
    else if (o_stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign o_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: queue-based pipeline model,
// directed plan cases followed by random traffic.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs, rt, rw_d;
  logic       use_rs, use_rt;
  logic       regwr_d, memread_d;
  logic [4:0] rw_ex, rw_mem, rw_w;
  logic       flush;
  logic [1:0] asrc, bsrc;
  logic       stall, exw, memw, wbw;
`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rs        (rs),
    .i_rt        (rt),
    .i_use_rs    (use_rs),
    .i_use_rt    (use_rt),
    .i_rw_d      (rw_d),
    .i_regwr_d   (regwr_d),
    .i_memread_d (memread_d),
    .i_rw_ex     (rw_ex),
    .i_rw_mem    (rw_mem),
    .i_rw_w      (rw_w),
    .i_flush     (flush),
    .o_asrc      (asrc),
    .o_bsrc      (bsrc),
    .o_stall     (stall),
    .o_ex_regwr  (exw),
    .o_mem_regwr (memw),
    .o_wb_regwr  (wbw)
`ifdef HAZ_STALL_CNT_EN
    ,
    .o_stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } ins_t;

  typedef struct packed {
    logic [1:0]  a;
    logic [1:0]  b;
    logic        st;
    logic        exw;
    logic        mw;
    logic        ww;
    logic [31:0] cnt;
  } exp_t;

  ins_t        pipe[$];
  exp_t        sbq[$];
  int unsigned nstall;
  int          checks;
  int          errors;

  task automatic chk(input string n,
                     input longint act,
                     input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s act=%0d req=%0d t=%0t",
               n, act, req, $time);
    end
  endtask

  // pipe[0]=EX, [1]=MEM, [2]=WB
  function automatic logic [1:0] ref_sel(
    input logic u, input logic [4:0] x);
    if (!u || x == 0) return 2'd0;
    for (int i = 0; i < 3; i++)
      if (pipe[i].wr && pipe[i].rd == x)
        return 2'(i + 1);
    return 2'd0;
  endfunction

  task automatic step(input logic r,
                      input logic [4:0] a_rs,
                      input logic [4:0] a_rt,
                      input logic a_urs,
                      input logic a_urt,
                      input logic [4:0] a_rwd,
                      input logic a_rw,
                      input logic a_mr,
                      input logic a_fl);
    exp_t e;
    ins_t n;
    logic rd_hit;
    @(negedge clk);
    rst_n     = r;
    rs        = a_rs;
    rt        = a_rt;
    use_rs    = a_urs;
    use_rt    = a_urt;
    rw_d      = a_rwd;
    regwr_d   = a_rw;
    memread_d = a_mr;
    flush     = a_fl;
    rw_ex     = pipe[0].rd;
    rw_mem    = pipe[1].rd;
    rw_w      = pipe[2].rd;
    #1;
    rd_hit = (a_urs && a_rs != 0
              && a_rs == pipe[0].rd)
          || (a_urt && a_rt != 0
              && a_rt == pipe[0].rd);
    e.a   = ref_sel(a_urs, a_rs);
    e.b   = ref_sel(a_urt, a_rt);
    e.st  = pipe[0].ld && rd_hit;
    e.exw = pipe[0].wr;
    e.mw  = pipe[1].wr;
    e.ww  = pipe[2].wr;
    e.cnt = nstall;
    sbq.push_back(e);
    if (!r) begin
      foreach (pipe[i]) pipe[i] = '0;
      nstall = 0;
    end else begin
      if (e.st && nstall != 32'hffff_ffff)
        nstall++;
      n.rd = a_rwd;
      n.wr = !(e.st || a_fl) && a_rw
             && a_rwd != 0;
      n.ld = n.wr && a_mr;
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
  endtask

  task automatic rnd_step();
    step($urandom_range(0, 49) != 0,
         5'($urandom_range(0, 7)),
         5'($urandom_range(0, 7)),
         1'($urandom), 1'($urandom),
         5'($urandom_range(0, 7)),
         1'($urandom), 1'($urandom),
         $urandom_range(0, 9) == 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("asrc", asrc, e.a);
        chk("bsrc", bsrc, e.b);
        chk("stall", stall, e.st);
        chk("ex_regwr", exw, e.exw);
        chk("mem_regwr", memw, e.mw);
        chk("wb_regwr", wbw, e.ww);
`ifdef HAZ_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, e.cnt);
`endif
      end
    end
  end

  initial begin : stim
    checks = 0;
    errors = 0;
    nstall = 0;
    rst_n = 0; rs = 0; rt = 0;
    use_rs = 0; use_rt = 0;
    rw_d = 5; regwr_d = 1; memread_d = 0;
    rw_ex = 0; rw_mem = 0; rw_w = 0;
    flush = 0;
    repeat (3) pipe.push_back('0);
    @(posedge clk);
    // reset held with a pending writer
    step(0, 0, 0, 0, 0, 5, 1, 0, 0);
    step(0, 5, 5, 1, 1, 5, 1, 0, 0);
    // forward EX -> MEM -> WB -> none
    step(1, 0, 0, 0, 0, 3, 1, 0, 0);
    step(1, 3, 3, 1, 1, 0, 0, 0, 0);
    step(1, 3, 3, 1, 1, 0, 0, 0, 0);
    step(1, 3, 3, 1, 1, 0, 0, 0, 0);
    step(1, 3, 3, 1, 1, 0, 0, 0, 0);
    // priority EX over MEM
    step(1, 0, 0, 0, 0, 4, 1, 0, 0);
    step(1, 0, 0, 0, 0, 4, 1, 0, 0);
    step(1, 4, 0, 1, 0, 0, 0, 0, 0);
    // load-use stall then MEM forward
    step(1, 0, 0, 0, 0, 7, 1, 1, 0);
    step(1, 0, 7, 0, 1, 0, 0, 0, 0);
    step(1, 0, 7, 0, 1, 0, 0, 0, 0);
    // back-to-back dependent loads
    step(1, 0, 0, 0, 0, 2, 1, 1, 0);
    step(1, 2, 0, 1, 0, 6, 1, 1, 0);
    step(1, 2, 0, 1, 0, 6, 1, 1, 0);
    step(1, 6, 0, 1, 0, 0, 0, 0, 0);
    step(1, 6, 0, 1, 0, 0, 0, 0, 0);
    // r0 and unused operand
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 6, 1, 1, 0);
    step(1, 0, 6, 0, 0, 0, 0, 0, 0);
    // flush squashes r9
    step(1, 0, 0, 0, 0, 9, 1, 0, 1);
    step(1, 9, 9, 1, 1, 0, 0, 0, 0);
    step(1, 9, 9, 1, 1, 0, 0, 0, 0);
    step(1, 9, 9, 1, 1, 0, 0, 0, 0);
    // flush with load-use stall together
    step(1, 0, 0, 0, 0, 5, 1, 1, 0);
    step(1, 5, 0, 1, 0, 5, 1, 0, 1);
    step(1, 5, 0, 1, 0, 0, 0, 0, 0);
    // reset with a stall pending
    step(1, 0, 0, 0, 0, 3, 1, 1, 0);
    step(0, 3, 0, 1, 0, 0, 0, 0, 0);
    step(1, 3, 0, 1, 0, 0, 0, 0, 0);
    repeat (500) rnd_step();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    #4;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d req=0",
               sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
